sd_spi_master: RTL and testbench
================================

// Module: sd_spi_master
// PURPOSE
//   Byte-level SPI master (mode 0, MSB first) driving the SD card SPI pins sck/cs/mosi and sampling miso.
//   Upstream command/data logic pushes one byte at a time over a valid/ready handshake.
//   Each byte sent returns one received byte on rx_valid/rx_data.
//   Owns the SCK divider, chip-select sequencing and the idle-high MOSI level that SD cards need.
// PARAMETERS
//   CLK_DIV      4   SCK half-period in clk cycles (>=1); f_sck = f_clk/(2*CLK_DIV)
//   DUMMY_BYTES  10  byte count of the power-up dummy-clock burst (only with SD_SPI_DUMMY_CLK_EN)
// PORTS
//   clk          in   1  system clock
//   reset        in   1  asynchronous, active-high reset
//   tx_valid     in   1  byte to send is present on tx_data
//   tx_ready     out  1  engine idle; byte accepted when tx_valid&&tx_ready at posedge clk
//   tx_data      in   8  byte to shift out, MSB first
//   rx_valid     out  1  one-cycle pulse: rx_data holds the byte received during the last transfer
//   rx_data      out  8  received byte; holds until the next rx_valid
//   cs_assert    in   1  level: 1 = select card (cs low) while not in a dummy burst
//   busy         out  1  transfer or dummy burst in progress (= ~tx_ready)
//   dummy_start  in   1  start dummy-clock burst (port exists only with SD_SPI_DUMMY_CLK_EN)
//   sck          out  1  SPI clock, idles low
//   cs           out  1  SPI chip select, active low
//   mosi         out  1  SPI data out, idles high
//   miso         in   1  SPI data in
// BEHAVIOUR
//   - Reset (async): state IDLE, sck=0, cs=1, mosi=1, rx_valid=0, rx_data=8'h00, divider=0, bit count=0.
//     After reset release: tx_ready=1, busy=0. A reset mid-transfer aborts the transfer; no rx_valid is issued.
//   - States: IDLE, SHIFT, and DUMMY (DUMMY only with the macro). tx_ready=(state==IDLE).
//   - IDLE: cs <= ~cs_assert every cycle; sck=0; mosi=1.
//     On accept at edge T: latch tx_data, enter SHIFT, mosi=tx_data[7] from T.
//   - SHIFT: divider counts CLK_DIV clk cycles per half period; sck toggles at each expiry.
//     Rising edge k (k=1..8) at T+(2k-1)*CLK_DIV: shift miso into rx shift register (MSB first).
//     Falling edge k at T+2k*CLK_DIV, k<8: mosi <= next bit.
//     Falling edge 8 at T+16*CLK_DIV: rx_data <= assembled byte, rx_valid=1 for exactly that cycle,
//     mosi=1, state IDLE, tx_ready=1 in the same cycle.
//   - Latency: accept to rx_valid = 16*CLK_DIV clk cycles; exactly 8 sck rising edges per byte.
//   - Back-to-back: tx_valid held high is accepted in the rx_valid cycle. sck stays low for at least one clk between bytes.
//   - cs is frozen during SHIFT; a cs_assert change mid-byte takes effect on the first IDLE edge after rx_valid.
//   - tx_data/tx_valid changes while busy are ignored.
//   - CLK_DIV=1: sck toggles every clk, so f_sck = f_clk/2.
// CONFIGURATION
//   SD_SPI_DUMMY_CLK_EN defined:
//     - dummy_start port and DUMMY state are present.
//     - In IDLE, dummy_start=1 enters DUMMY and takes priority over tx_valid; that byte is not accepted.
//     - DUMMY: cs=1, mosi=1, DUMMY_BYTES*8 full sck pulses at the same CLK_DIV timing. No rx_valid is issued.
//       Then IDLE; cs resumes following cs_assert.
//   SD_SPI_DUMMY_CLK_EN undefined:
//     - dummy_start port, DUMMY state and DUMMY_BYTES logic are absent.
//     - Software issues init clocks itself by sending 0xFF bytes with cs_assert=0.
// TESTING
//   1 reset asserted mid-idle -> sck=0, cs=1, mosi=1, rx_valid=0, rx_data=0x00; after release tx_ready=1, busy=0.
//   2 CLK_DIV=2, cs_assert=1, send 0xA5, miso model returns 0x3C ->
//     cs=0 before first sck rise; mosi sampled at sck rises = 1,0,1,0,0,1,0,1;
//     8 rises; rx_valid 1 cycle at T+32; rx_data=0x3C.
//   3 tx_valid held with 0x40 then 0x00 -> 2nd byte accepted in the 1st byte's rx_valid cycle;
//     16 sck rises total; sck low >=1 clk between bytes.
//   4 cs_assert dropped to 0 at bit 3 of byte 0xFF -> cs stays 0 through rx_valid, goes 1 on the following edge.
//   5 reset pulsed after 3rd sck rise -> outputs return to reset values at once; no rx_valid;
//     next byte 0x12 transfers correctly.
//   6 [SD_SPI_DUMMY_CLK_EN, DUMMY_BYTES=10, CLK_DIV=2] dummy_start and tx_valid same cycle ->
//     80 sck pulses, cs=1, mosi=1 throughout, tx_ready=0 for 320 clk, no rx_valid; the pending byte is accepted afterwards.

Source files
------------

// File: rtl/sd_spi_master.sv
// sd_spi_master: byte-level SPI master for SD cards (mode 0, MSB first).
// Upstream logic hands over one byte at a time on tx_valid/tx_ready and gets
// the byte clocked in from miso back as a one-cycle rx_valid pulse. The block
// owns the SCK divider, chip-select sequencing and the idle-high MOSI level.
//
// Optional feature, macro SD_SPI_DUMMY_CLK_EN: adds the dummy_start port and a
// DUMMY state that sends DUMMY_BYTES*8 SCK pulses with cs and mosi held high.
// This is the power-up clocking that SD cards need. Without the macro, software
// sends 0xFF bytes with cs_assert=0 to get the same effect.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | engine free, tx_ready=1, cs follows ~cs_assert, sck=0, mosi=1
// SHIFT | one byte in flight, 8 sck pulses, cs frozen
// DUMMY | power-up clock burst, cs=1, mosi=1 (macro build only)

module sd_spi_master #(
  parameter int CLK_DIV     = 4
`ifdef SD_SPI_DUMMY_CLK_EN
  ,
  parameter int DUMMY_BYTES = 10
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       cs_assert,
  output logic       busy,
`ifdef SD_SPI_DUMMY_CLK_EN
  input  logic       dummy_start,
`endif
  output logic       sck,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  // Half-period timer is a down-counter reloaded with CLK_DIV-1; sck toggles
  // when it reads zero, so CLK_DIV=1 toggles sck on every clk.
  localparam int              DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);

`ifdef SD_SPI_DUMMY_CLK_EN
  localparam int              DUMMY_PULSES = DUMMY_BYTES * 8;
  localparam int              DCW          = (DUMMY_PULSES > 1) ? $clog2(DUMMY_PULSES) : 1;
  localparam logic [DCW-1:0]  DUMMY_LAST   = DCW'(DUMMY_PULSES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DUMMY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
`endif

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  // Only the seven bits still to be sent are kept; bit 7 leaves on accept.
  logic [6:0]       tx_shift;
  logic [7:0]       rx_shift;
`ifdef SD_SPI_DUMMY_CLK_EN
  // Pulses remaining in the burst, counted down on each falling sck edge.
  logic [DCW-1:0]   dummy_cnt;
`endif

  assign tx_ready = (state == IDLE);
  assign busy     = ~tx_ready;

  // Sequencer: divider, bit timing, pin levels and the received-byte pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sck       <= 1'b0;
      cs        <= 1'b1;
      mosi      <= 1'b1;
      rx_valid  <= 1'b0;
      rx_data   <= 8'h00;
      div_cnt   <= '0;
      bit_cnt   <= 3'd0;
      tx_shift  <= 7'h00;
      rx_shift  <= 8'h00;
`ifdef SD_SPI_DUMMY_CLK_EN
      dummy_cnt <= '0;
`endif
    end else begin
      rx_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          sck  <= 1'b0;
          mosi <= 1'b1;
          cs   <= ~cs_assert;
`ifdef SD_SPI_DUMMY_CLK_EN
          // The burst wins over a pending byte; that byte waits for IDLE.
          if (dummy_start) begin
            state     <= DUMMY;
            cs        <= 1'b1;
            div_cnt   <= DIV_RELOAD;
            dummy_cnt <= DUMMY_LAST;
          end else
`endif
          if (tx_valid) begin
            state    <= SHIFT;
            mosi     <= tx_data[7];
            tx_shift <= tx_data[6:0];
            div_cnt  <= DIV_RELOAD;
            bit_cnt  <= 3'd0;
          end
        end

        SHIFT: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - DIV_W'(1);
          end else begin
            div_cnt <= DIV_RELOAD;
            sck     <= ~sck;
            if (!sck) begin
              rx_shift <= {rx_shift[6:0], miso};
            end else if (bit_cnt == 3'd7) begin
              // Eighth falling edge: hand the byte up and free the engine
              // in the same cycle so a held tx_valid goes out back-to-back.
              sck      <= 1'b0;
              mosi     <= 1'b1;
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
              state    <= IDLE;
            end else begin
              mosi     <= tx_shift[6];
              tx_shift <= {tx_shift[5:0], 1'b1};
              bit_cnt  <= bit_cnt + 3'd1;
            end
          end
        end

`ifdef SD_SPI_DUMMY_CLK_EN
        DUMMY: begin
          cs   <= 1'b1;
          mosi <= 1'b1;
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - DIV_W'(1);
          end else begin
            div_cnt <= DIV_RELOAD;
            sck     <= ~sck;
            if (sck) begin
              if (dummy_cnt == '0) begin
                state <= IDLE;
              end else begin
                dummy_cnt <= dummy_cnt - DCW'(1);
              end
            end
          end
        end
`endif

        default: begin
          state <= IDLE;
          sck   <= 1'b0;
          mosi  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_master.sv
// tb_sd_spi_master: directed and randomized checks of sd_spi_master with
// CLK_DIV=2. A behavioural SD-card model feeds miso from a bit list and logs
// mosi/cs at each sck rise; expectations come from the byte values alone.
module tb_sd_spi_master;

  localparam int CLK_DIV = 2;
  localparam int LAT     = 16 * CLK_DIV;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       tx_valid  = 1'b0;
  logic [7:0] tx_data   = 8'h00;
  logic       cs_assert = 1'b0;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       sck;
  logic       cs;
  logic       mosi;
  logic       miso;
`ifdef SD_SPI_DUMMY_CLK_EN
  logic       dummy_start = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Card model: queued response bits, one consumed per sck rise.
  logic slave_bits [0:511];
  int   slave_wr = 0;
  int   slave_rd = 0;
  // Line log captured at each sck rise.
  logic mosi_bits [0:511];
  logic cs_bits   [0:511];
  int   rise_cnt = 0;

  sd_spi_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .cs_assert (cs_assert),
    .busy      (busy),
`ifdef SD_SPI_DUMMY_CLK_EN
    .dummy_start (dummy_start),
`endif
    .sck       (sck),
    .cs        (cs),
    .mosi      (mosi),
    .miso      (miso)
  );

  always #5 clk = ~clk;

  assign miso = (slave_rd < slave_wr) ? slave_bits[slave_rd] : 1'b1;

  always @(posedge sck) begin
    if (rise_cnt < 512) begin
      mosi_bits[rise_cnt] = mosi;
      cs_bits[rise_cnt]   = cs;
    end
    rise_cnt = rise_cnt + 1;
    if (slave_rd < slave_wr) slave_rd = slave_rd + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_card(input logic [7:0] rsp);
    for (int i = 7; i >= 0; i--) begin
      slave_bits[slave_wr] = rsp[i];
      slave_wr++;
    end
  endtask

  function automatic logic [15:0] mosi_word(input int base, input int n);
    logic [15:0] w;
    w = 16'h0000;
    for (int i = 0; i < n; i++) w = {w[14:0], mosi_bits[base + i]};
    return w;
  endfunction

  function automatic int cs_high_count(input int base, input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) if (cs_bits[base + i] !== 1'b0) c++;
    return c;
  endfunction

  // One byte through the engine; cs_drop>=0 releases cs_assert after that
  // many sck rises and checks that cs only follows once the byte is done.
  task automatic xfer(input logic [7:0] tx, input logic [7:0] rsp, input int cs_drop);
    int base;
    int lat;
    @(negedge clk);
    check("ready_before_send", tx_ready, 1'b1);
    slave_wr = slave_rd;
    load_card(rsp);
    base     = rise_cnt;
    tx_data  = tx;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    check("busy_after_accept", busy, 1'b1);
    lat = 0;
    while (!rx_valid && lat < 4 * LAT) begin
      @(posedge clk); #1;
      lat++;
      if (cs_drop >= 0 && rise_cnt - base >= cs_drop) cs_assert = 1'b0;
    end
    check("latency", lat, LAT);
    check("rx_data", rx_data, rsp);
    check("sck_rises", rise_cnt - base, 8);
    check("mosi_bits", mosi_word(base, 8), {8'h00, tx});
    check("cs_low_at_rises", cs_high_count(base, 8), 0);
    check("ready_in_rx_cycle", tx_ready, 1'b1);
    check("mosi_idle_high", mosi, 1'b1);
    if (cs_drop >= 0) check("cs_frozen_at_rx", cs, 1'b0);
    @(posedge clk); #1;
    check("rx_valid_one_cycle", rx_valid, 1'b0);
    if (cs_drop >= 0) check("cs_follows_after_rx", cs, 1'b1);
  endtask

  initial begin
    int base;
    int lat;
    int nrx;
    int bad;
    logic [7:0] r0;
    logic [7:0] r1;

    // Reset values while held, then idle handshake after release.
    repeat (3) @(posedge clk);
    #1;
    check("rst_sck", sck, 1'b0);
    check("rst_cs", cs, 1'b1);
    check("rst_mosi", mosi, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rel_tx_ready", tx_ready, 1'b1);
    check("rel_busy", busy, 1'b0);
    cs_assert = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("cs_follows_idle", cs, 1'b0);
    // Reset pulsed mid-idle.
    #2 reset = 1'b1;
    #1;
    check("idle_rst_cs", cs, 1'b1);
    check("idle_rst_sck", sck, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // 0xA5 out, 0x3C back.
    xfer(8'hA5, 8'h3C, -1);

    // Randomized bytes.
    repeat (6) xfer(8'($urandom), 8'($urandom), -1);

    // Back-to-back with tx_valid held: 0x40 then 0x00.
    r0 = 8'($urandom);
    r1 = 8'($urandom);
    @(negedge clk);
    slave_wr = slave_rd;
    load_card(r0);
    load_card(r1);
    base     = rise_cnt;
    tx_data  = 8'h40;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!rx_valid && lat < 4 * LAT) begin @(posedge clk); #1; lat++; end
    check("b2b_latency0", lat, LAT);
    check("b2b_rx0", rx_data, r0);
    check("b2b_gap_sck_low", sck, 1'b0);
    tx_data = 8'h00;
    @(posedge clk); #1;
    check("b2b_accept_in_rx_cycle", busy, 1'b1);
    check("b2b_gap_sck_low2", sck, 1'b0);
    tx_valid = 1'b0;
    lat = 0;
    while (!rx_valid && lat < 4 * LAT) begin @(posedge clk); #1; lat++; end
    check("b2b_latency1", lat, LAT);
    check("b2b_rx1", rx_data, r1);
    check("b2b_rises", rise_cnt - base, 16);
    check("b2b_mosi", mosi_word(base, 16), 16'h4000);
    @(posedge clk); #1;

    // cs_assert dropped after bit 3 of 0xFF.
    xfer(8'hFF, 8'hC3, 3);
    cs_assert = 1'b1;
    repeat (2) @(posedge clk);

    // Reset after the third sck rise aborts the byte.
    @(negedge clk);
    slave_wr = slave_rd;
    load_card(8'h81);
    base     = rise_cnt;
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    lat = 0;
    while (rise_cnt - base < 3 && lat < 4 * LAT) begin @(posedge clk); #1; lat++; end
    check("abort_reached_rise3", rise_cnt - base, 3);
    #2 reset = 1'b1;
    #1;
    check("abort_sck", sck, 1'b0);
    check("abort_cs", cs, 1'b1);
    check("abort_mosi", mosi, 1'b1);
    check("abort_rx_valid", rx_valid, 1'b0);
    check("abort_rx_data", rx_data, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    nrx = 0;
    repeat (2 * LAT) begin @(posedge clk); #1; if (rx_valid) nrx++; end
    check("abort_no_rx_valid", nrx, 0);
    xfer(8'h12, 8'($urandom), -1);

`ifdef SD_SPI_DUMMY_CLK_EN
    // Dummy burst wins over a simultaneous byte; byte goes out afterwards.
    @(negedge clk);
    slave_wr    = slave_rd;
    base        = rise_cnt;
    tx_data     = 8'h77;
    tx_valid    = 1'b1;
    dummy_start = 1'b1;
    @(posedge clk); #1;
    dummy_start = 1'b0;
    lat = 0;
    bad = 0;
    nrx = 0;
    while (!tx_ready && lat < 1000) begin
      if (cs !== 1'b1 || mosi !== 1'b1) bad++;
      if (rx_valid) nrx++;
      @(posedge clk); #1;
      lat++;
    end
    check("dummy_busy_cycles", lat, 320);
    check("dummy_rises", rise_cnt - base, 80);
    check("dummy_cs_mosi_high", bad, 0);
    check("dummy_no_rx_valid", nrx, 0);
    r0 = 8'($urandom);
    load_card(r0);
    base = rise_cnt;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    check("dummy_pending_accepted", busy, 1'b1);
    lat = 0;
    while (!rx_valid && lat < 4 * LAT) begin @(posedge clk); #1; lat++; end
    check("dummy_after_rx", rx_data, r0);
    check("dummy_after_mosi", mosi_word(base, 8), 16'h0077);
    @(posedge clk); #1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
